fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one FIFO write port among N_REQ valid/ready requesters,
//           granting bursts of up to MAX_BURST words before forcing re-arbitration.
// Latency : one cycle from IDLE to first grant; zero-latency combinational path from owner to FIFO.
// Backpr. : fifo_full drops the owner's ready and write_enable; grant and burst count hold meanwhile.
// Ports   : clk, arst_n (async active-low); req_valid/req_data/req_ready per requester;
//           fifo_full in, write_enable/data_i out to FIFO; grant_valid/grant_id show registered owner.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 6,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       write_enable,
  output logic [DATA_W-1:0]          data_i,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_REQ  = IDW'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] last_grant;
  logic [BW-1:0]  burst_cnt;

  logic           any_valid;
  logic           owner_valid;
  logic           xfer;
  logic           release_now;
  logic [IDW-1:0] winner;

  // First valid requester after 'base', wrapping; 'base' itself is the last candidate.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                             input logic [IDW-1:0]   base);
    logic [IDW-1:0] w;
    logic [IDW-1:0] cand;
    logic           hit;
    int             idx;
    w   = '0;
    hit = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(base) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IDW'(idx);
      if (!hit && v[cand]) begin
        hit = 1'b1;
        w   = cand;
      end
    end
    return w;
  endfunction

  assign any_valid   = |req_valid;
  assign owner_valid = req_valid[owner];
  assign xfer        = (state == GRANT) && owner_valid && !fifo_full;
  // Release either because the owner went away or because it used up its burst.
  assign release_now = (state == GRANT) && (!owner_valid || (xfer && (burst_cnt == LAST_BEAT)));
  // In GRANT last_grant always equals owner, so one search serves both IDLE and release.
  assign winner      = rr_pick(req_valid, last_grant);

  always_comb begin
    req_ready = '0;
    if (state == GRANT && !fifo_full) req_ready[owner] = 1'b1;
  end

  assign write_enable = xfer;
  assign data_i       = (state == GRANT) ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
  assign grant_valid  = (state == GRANT);
  assign grant_id     = owner;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      owner      <= '0;
      burst_cnt  <= '0;
      last_grant <= LAST_REQ;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state      <= GRANT;
            owner      <= winner;
            last_grant <= winner;
            burst_cnt  <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            // Hand straight over to the next requester without an idle bubble.
            if (any_valid) begin
              owner      <= winner;
              last_grant <= winner;
              burst_cnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           write_enable;
  logic [W-1:0]   data_i;
  logic           grant_valid;
  logic [1:0]     grant_id;

  logic [N-1:0]   v1;
  logic [N*W-1:0] d1;
  logic [N-1:0]   req_ready1;
  logic           write_enable1;
  logic [W-1:0]   data_i1;
  logic           grant_valid1;
  logic [1:0]     grant_id1;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(4)) u_dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .write_enable(write_enable),
    .data_i(data_i), .grant_valid(grant_valid), .grant_id(grant_id));

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .arst_n(arst_n), .req_valid(v1), .req_data(d1),
    .req_ready(req_ready1), .fifo_full(1'b0), .write_enable(write_enable1),
    .data_i(data_i1), .grant_valid(grant_valid1), .grant_id(grant_id1));

  typedef struct {
    bit act;
    int own;
    int left;
    int last;
  } mst_t;

  typedef struct {
    bit           act;
    int           own;
    bit           wr;
    logic [W-1:0] dat;
    logic [N-1:0] rdy;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  mst_t s0, s1;
  int   checks = 0;
  int   passes = 0;
  int   acc = -1;
  bit   stim_done = 1'b0;

  localparam mst_t S_RST = '{act: 1'b0, own: 0, left: 0, last: N - 1};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int rr(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  // Reference arbiter: counts remaining words in the burst down to zero.
  task automatic step(inout mst_t s, input logic [N-1:0] v, input bit full, input int mb,
                      output bit wr, output int wid);
    bit rel;
    rel = 1'b0;
    wr  = 1'b0;
    wid = 0;
    if (!s.act) begin
      if (v != 0) begin
        s.act = 1'b1; s.own = rr(v, s.last); s.last = s.own; s.left = mb;
      end
    end else begin
      if (!v[s.own]) rel = 1'b1;
      else if (!full) begin
        wr = 1'b1; wid = s.own; s.left--;
        if (s.left == 0) rel = 1'b1;
      end
      if (rel) begin
        if (v != 0) begin
          s.own = rr(v, s.own); s.last = s.own; s.left = mb;
        end else s.act = 1'b0;
      end
    end
  endtask

  function automatic rec_t snap(input mst_t s, input logic [N*W-1:0] d, input bit full);
    rec_t r;
    r.act = s.act;
    r.own = s.own;
    r.wr  = 1'b0;
    r.dat = s.act ? d[s.own*W +: W] : '0;
    r.rdy = '0;
    if (s.act && !full) r.rdy[s.own] = 1'b1;
    return r;
  endfunction

  // md=0: requester i is valid whenever free and mk[i]; md=1: random. fpct = full percentage.
  task automatic drive_and_model(input int md, input logic [N-1:0] mk, input int fpct);
    rec_t r;
    bit   wr;
    int   wid;
    for (int i = 0; i < N; i++) begin
      if (!(req_valid[i] && acc != i)) begin
        req_valid[i] = (md == 0) ? mk[i] : ($urandom_range(0, 1) == 1);
        if (req_valid[i]) req_data[i*W +: W] = W'($urandom);
      end
    end
    fifo_full = ($urandom_range(0, 99) < fpct);
    r = snap(s0, req_data, fifo_full);
    step(s0, req_valid, fifo_full, 4, wr, wid);
    r.wr = wr;
    q0.push_back(r);
    acc = wr ? wid : -1;
    r = snap(s1, d1, 1'b0);
    step(s1, v1, 1'b0, 1, wr, wid);
    r.wr = wr;
    q1.push_back(r);
  endtask

  task automatic run(input int n, input int md, input logic [N-1:0] mk, input int fpct);
    repeat (n) begin
      @(negedge clk);
      drive_and_model(md, mk, fpct);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations, away from the clock edge.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #2;
      if (arst_n && !stim_done) begin
        if (q0.size() == 0) begin
          checks++;
          $display("FAIL q0_underflow: got empty queue expected a record (t=%0t)", $time);
        end else begin
          r = q0.pop_front();
          chk("grant_valid", grant_valid, r.act);
          if (r.act) chk("grant_id", grant_id, r.own);
          chk("write_enable", write_enable, r.wr);
          chk("data_i", data_i, r.dat);
          chk("req_ready", req_ready, r.rdy);
        end
        if (q1.size() == 0) begin
          checks++;
          $display("FAIL q1_underflow: got empty queue expected a record (t=%0t)", $time);
        end else begin
          r = q1.pop_front();
          chk("mb1_grant_valid", grant_valid1, r.act);
          if (r.act) chk("mb1_grant_id", grant_id1, r.own);
          chk("mb1_write_enable", write_enable1, r.wr);
          chk("mb1_data_i", data_i1, r.dat);
        end
      end
    end
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    v1        = 4'b0111;
    d1        = {6'd13, 6'd12, 6'd11, 6'd10};
    s0        = S_RST;
    s1        = S_RST;

    #12;
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_data_i", data_i, 0);

    // Single requester: continuous writes, regranted after each burst.
    @(negedge clk);
    arst_n = 1'b1;
    drive_and_model(0, 4'b0001, 0);
    run(13, 0, 4'b0001, 0);
    // All requesting: 0,1,2,3 round robin, then a full stall mid-burst.
    run(20, 0, 4'b1111, 0);
    run(6, 0, 4'b1111, 0);
    run(3, 0, 4'b1111, 100);
    run(12, 0, 4'b1111, 0);
    // 0101 with requester 0 dropping after an accept, then returning.
    run(3, 0, 4'b0101, 0);
    run(4, 0, 4'b0100, 0);
    run(10, 0, 4'b0101, 0);
    // Random traffic with random full.
    run(300, 1, 4'b0000, 25);

    // Asynchronous reset between edges during a burst.
    run(5, 0, 4'b1111, 0);
    @(negedge clk);
    drive_and_model(0, 4'b1111, 0);
    #4;
    arst_n = 1'b0;
    #1;
    chk("arst_write_enable", write_enable, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_grant_valid", grant_valid, 0);
    chk("arst_data_i", data_i, 0);
    chk("arst_mb1_grant_valid", grant_valid1, 0);
    s0 = S_RST;
    s1 = S_RST;
    req_valid = '0;
    acc = -1;
    @(negedge clk);
    arst_n = 1'b1;
    drive_and_model(0, 4'b1010, 0);
    run(15, 0, 4'b1010, 0);

    #3;
    stim_done = 1'b1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
